// File: rtl/mult32x32_ctrl.sv
// ============================================================================
// Module      : mult32x32_ctrl
// Description : Sequencer for the 32x32 multiplier datapath; walks the eight
//               8x16 partial products. Optional zero-skip: MULT_ZERO_SKIP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mult32x32_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [1:0]  a_sel,
   output logic        b_sel,
   output logic [2:0]  shift_sel,
   output logic        upd_prod,
   output logic        clr_prod
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PP   = 1'b1
   } state_t;

   localparam logic [2:0] c_LAST_STEP = 3'd7;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_k, w_k_nxt;
   logic       r_done, w_done_nxt;

`ifdef MULT_ZERO_SKIP_EN
   logic [7:0] r_mask, w_mask_nxt;
   logic [7:0] w_mask_start, w_pick_src, w_mask_rem;
   logic [2:0] w_first;
   logic       w_any;

   // Step k is useful only when both its A byte and its B half-word are non-zero.
   always_comb begin
      w_mask_start = 8'd0;
      for (int k = 0; k < 8; k++) begin
         w_mask_start[k] = (a[8*(k%4) +: 8] != 8'd0) && (b[16*(k/4) +: 16] != 16'd0);
      end
   end

   assign w_pick_src = (r_state == S_IDLE) ? w_mask_start : r_mask;
   assign w_any      = |w_pick_src;

   always_comb begin
      w_first = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_pick_src[k]) w_first = k[2:0];
      end
   end

   assign w_mask_rem = w_pick_src & ~(8'd1 << w_first);
`else
   logic w_unused_ops;
   assign w_unused_ops = ^{a, b};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= 3'd0;
         r_done  <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
         r_mask  <= 8'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_done  <= w_done_nxt;
`ifdef MULT_ZERO_SKIP_EN
         r_mask  <= w_mask_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_done_nxt  = 1'b0;
`ifdef MULT_ZERO_SKIP_EN
      w_mask_nxt  = r_mask;
`endif
      busy      = 1'b0;
      done      = r_done;
      a_sel     = 2'd0;
      b_sel     = 1'b0;
      shift_sel = 3'd0;
      upd_prod  = 1'b0;
      clr_prod  = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Gated with reset so every output is low while reset is held.
            clr_prod = start & ~reset;
            if (start) begin
`ifdef MULT_ZERO_SKIP_EN
               w_mask_nxt = w_mask_rem;
               if (w_any) begin
                  w_state_nxt = S_PP;
                  w_k_nxt     = w_first;
               end else begin
                  w_done_nxt  = 1'b1;
               end
`else
               w_state_nxt = S_PP;
               w_k_nxt     = 3'd0;
`endif
            end
         end
         S_PP: begin
            busy      = 1'b1;
            upd_prod  = 1'b1;
            a_sel     = r_k[1:0];
            b_sel     = r_k[2];
            shift_sel = {1'b0, r_k[1:0]} + {1'b0, r_k[2], 1'b0};
`ifdef MULT_ZERO_SKIP_EN
            w_mask_nxt = w_mask_rem;
            if (w_any) begin
               w_k_nxt = w_first;
            end else begin
               w_state_nxt = S_IDLE;
               w_k_nxt     = 3'd0;
               w_done_nxt  = 1'b1;
            end
`else
            if (r_k == c_LAST_STEP) begin
               w_state_nxt = S_IDLE;
               w_k_nxt     = 3'd0;
               w_done_nxt  = 1'b1;
            end else begin
               w_k_nxt = r_k + 3'd1;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mult32x32_ctrl.sv
// Testbench for mult32x32_ctrl with a behavioural accumulator standing in for
// the arithmetic unit; products checked against a*b from a scoreboard queue.
`default_nettype none

module tb_mult32x32_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done, b_sel, upd_prod, clr_prod;
   logic [1:0]  a_sel;
   logic [2:0]  shift_sel;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   mult32x32_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .a_sel(a_sel), .b_sel(b_sel),
      .shift_sel(shift_sel), .upd_prod(upd_prod), .clr_prod(clr_prod)
   );

   always #5 clk = ~clk;

   // Arithmetic unit model
   logic [7:0]  pa;
   logic [15:0] pb;
   logic [63:0] pp, acc;
   always_comb begin
      pa = a[8*a_sel +: 8];
      pb = b[16*b_sel +: 16];
      pp = (64'(pa) * 64'(pb)) << (8*shift_sel);
   end
   always @(posedge clk) begin
      if (clr_prod)      acc <= 64'd0;
      else if (upd_prod) acc <= acc + pp;
   end

   function automatic logic [7:0] exp_mask(input logic [31:0] x, input logic [31:0] y);
      logic [7:0] m;
      m = 8'hFF;
`ifdef MULT_ZERO_SKIP_EN
      for (int k = 0; k < 8; k++)
         m[k] = (x[8*(k%4) +: 8] != 8'd0) && (y[16*(k/4) +: 16] != 16'd0);
`endif
      return m;
   endfunction

   function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
      return $countones(exp_mask(x, y)) + 1;
   endfunction

   // Drives a start pulse in cycle T; returns inside T after clr_prod has settled.
   task automatic launch(input logic [31:0] ta, input logic [31:0] tbv);
      @(posedge clk); #1;
      a = ta; b = tbv; start = 1'b1;
      #1;
      exp_q.push_back(64'(ta) * 64'(tbv));
   endtask

   // Advances until done; cyc is cycles after T (-1 on timeout).
   task automatic wait_done(output int cyc, output int nupd);
      cyc = -1; nupd = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1; start = 1'b0; #1;
         if (upd_prod) nupd++;
         if (done) begin cyc = c; break; end
      end
   endtask

   task automatic test_reset;
      logic [9:0] o;
      reset = 1'b1; start = 1'b1; a = '0; b = '0;
      #2;
      o = {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod};
      checks++;
      if (o !== 10'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", o); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; #1;
      o = {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod};
      checks++;
      if (o !== 10'd0) begin failures++; $display("FAIL idle_after_reset got=%b exp=0", o); end
   endtask

   task automatic test_basic;
      int shifts[8] = '{0, 1, 2, 3, 2, 3, 4, 5};
      logic [63:0] e;
      logic [7:0] got, want;
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if ({clr_prod, busy} !== 2'b10) begin failures++; $display("FAIL basic_start clr,busy got=%b exp=10", {clr_prod, busy}); end
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1; start = 1'b0; #1;
         got  = {a_sel, b_sel, shift_sel, upd_prod, busy};
         want = {2'(j % 4), 1'(j / 4), 3'(shifts[j]), 1'b1, 1'b1};
         checks++;
         if (got !== want || clr_prod !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL basic_step%0d got=%b exp=%b", j, got, want);
         end
      end
      @(posedge clk); #1; #1;
      checks++;
      if ({done, busy, upd_prod} !== 3'b100) begin failures++; $display("FAIL basic_done done,busy,upd got=%b exp=100", {done, busy, upd_prod}); end
      e = exp_q.pop_front();
      checks++;
      if (acc !== e || e !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL basic_product got=%h exp=%h", acc, e); end
      @(posedge clk); #1; #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_operands;
      logic [31:0] ta[4] = '{32'd3, 32'h0000_0001, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] tb_[4] = '{32'd5, 32'h0001_0000, 32'h1234_5678, 32'h0000_0100};
      int cyc, nupd;
      logic [63:0] e;
      for (int i = 0; i < 4; i++) begin
         launch(ta[i], tb_[i]);
         wait_done(cyc, nupd);
         checks++;
         if (cyc !== exp_lat(ta[i], tb_[i])) begin failures++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, cyc, exp_lat(ta[i], tb_[i])); end
         checks++;
         if (nupd !== exp_lat(ta[i], tb_[i]) - 1) begin failures++; $display("FAIL op%0d_steps got=%0d exp=%0d", i, nupd, exp_lat(ta[i], tb_[i]) - 1); end
         e = exp_q.pop_front();
         checks++;
         if (acc !== e) begin failures++; $display("FAIL op%0d_product got=%h exp=%h", i, acc, e); end
      end
   endtask

   task automatic test_hold_start;
      int n, n_done, done_cyc;
      logic [63:0] e;
      n = exp_lat(32'hFFFF_FFFF, 32'd3) - 1;
      launch(32'hFFFF_FFFF, 32'd3);
      e = exp_q.pop_front();
      n_done = 0; done_cyc = -1;
      for (int c = 1; c <= n + 4; c++) begin
         @(posedge clk); #1; start = (c <= n); #1;
         if (done) begin
            n_done++; done_cyc = c;
            checks++;
            if (acc !== e) begin failures++; $display("FAIL hold_product got=%h exp=%h", acc, e); end
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1) begin failures++; $display("FAIL hold_done_count got=%0d exp=1", n_done); end
      checks++;
      if (done_cyc !== n + 1) begin failures++; $display("FAIL hold_done_cycle got=%0d exp=%0d", done_cyc, n + 1); end
   endtask

   task automatic test_back_to_back;
      int cyc, nupd;
      logic [63:0] e;
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, nupd);
      checks++;
      if (cyc !== 9) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=9", cyc); end
      e = exp_q.pop_front();
      checks++;
      if (acc !== e) begin failures++; $display("FAIL b2b_first_product got=%h exp=%h", acc, e); end
      a = 32'd2; b = 32'd7; start = 1'b1; #1;
      exp_q.push_back(64'd14);
      checks++;
      if ({clr_prod, done} !== 2'b11) begin failures++; $display("FAIL b2b_clr_with_done got=%b exp=11", {clr_prod, done}); end
      wait_done(cyc, nupd);
      checks++;
      if (cyc !== exp_lat(32'd2, 32'd7)) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, exp_lat(32'd2, 32'd7)); end
      e = exp_q.pop_front();
      checks++;
      if (acc !== e) begin failures++; $display("FAIL b2b_second_product got=%h exp=%h", acc, e); end
   endtask

   task automatic test_reset_mid;
      logic [9:0] o;
      int n_done, cyc, nupd;
      logic [63:0] e;
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1; start = 1'b0;
      end
      #1;
      checks++;
      if ({busy, upd_prod} !== 2'b11) begin failures++; $display("FAIL rst_mid_active got=%b exp=11", {busy, upd_prod}); end
      reset = 1'b1; start = 1'b1; #1;
      o = {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod};
      checks++;
      if (o !== 10'd0) begin failures++; $display("FAIL rst_mid_async got=%b exp=0", o); end
      void'(exp_q.pop_back());
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         if (done || busy) n_done++;
      end
      checks++;
      if (n_done !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", n_done); end
      launch(32'd10, 32'd10);
      wait_done(cyc, nupd);
      checks++;
      if (cyc !== exp_lat(32'd10, 32'd10)) begin failures++; $display("FAIL rst_restart_latency got=%0d exp=%0d", cyc, exp_lat(32'd10, 32'd10)); end
      e = exp_q.pop_front();
      checks++;
      if (acc !== e || e !== 64'd100) begin failures++; $display("FAIL rst_restart_product got=%h exp=%h", acc, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_operands();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
